voice_allocator: RTL

// Polyphonic voice scheduler: accepts note-on/note-off events, assigns them to NUM_VOICES

---
 rtl/voice_allocator_if.sv | 33 +++
 rtl/voice_allocator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator_if.sv
// Note-event handshake plus the shared 8-bit synth write bus.
// The tri-state data pin is resolved here from the master's data/enable pair.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic                  note_valid;
  logic                  note_on;
  logic [6:0]            note_key;
  logic [7:0]            note_incr;
  logic                  all_off;
  logic                  note_ready;
  logic [15:0]           bus_address;
  logic [7:0]            bus_data_o;
  logic                  bus_data_oe;
  wire  [7:0]            bus_data;
  logic                  bus_read_write;
  logic                  bus_clock;
  logic [NUM_VOICES-1:0] voice_active;

  assign bus_data = bus_data_oe ? bus_data_o : 8'hzz;

  modport master (
    input  note_valid, note_on, note_key, note_incr, all_off,
    output note_ready, bus_address, bus_data_o, bus_data_oe,
    output bus_read_write, bus_clock, voice_active
  );

  modport slave (
    output note_valid, note_on, note_key, note_incr, all_off,
    input  note_ready, bus_address, bus_data, bus_data_oe,
    input  bus_read_write, bus_clock, voice_active
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note events onto voices and programs them
// through 3-cycle writes (SETUP/STROBE/HOLD) on the shared synth bus.
module voice_allocator #(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          VOICE_STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  voice_allocator_if.master bus
);
  localparam int          VW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [15:0] STRIDE = 16'(VOICE_STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_SETUP, S_STROBE, S_HOLD} state_e;
  typedef enum logic [1:0] {OP_ON, OP_OFF, OP_ALL} op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [VW-1:0]         voice_q, voice_d;
  logic [VW-1:0]         steal_q, steal_d;
  logic                  second_q, second_d;
  logic [NUM_VOICES-1:0] pend_q, pend_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [6:0]            keys_q [NUM_VOICES];
  logic [6:0]            keys_d [NUM_VOICES];
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  bus_clock_q, bus_clock_d;
  logic [6:0]            key_q, key_d;
  logic [7:0]            incr_q, incr_d;

  logic                  note_ready;
  logic                  data_oe;
  logic                  accept;
  logic [NUM_VOICES-1:0] match;
  logic                  match_any, free_any;
  logic [VW-1:0]         match_idx, free_idx, on_voice, steal_next;
  logic                  has_write, more_write;

  function automatic logic [VW-1:0] lowest(input logic [NUM_VOICES-1:0] m);
    logic [VW-1:0] idx;
    idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (m[i]) idx = VW'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] reg_addr(input logic [VW-1:0] v, input logic [1:0] r);
    return BASE_ADDR + (16'(v) * STRIDE) + 16'(r);
  endfunction

  function automatic logic [NUM_VOICES-1:0] drop_lowest(input logic [NUM_VOICES-1:0] m);
    return m & (m - NUM_VOICES'(1));
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      match[v] = active_q[v] && (keys_q[v] == key_q);
    end
  end

  assign match_any  = |match;
  assign free_any   = ~&active_q;
  assign match_idx  = lowest(match);
  assign free_idx   = lowest(~active_q);
  assign steal_next = (steal_q == VW'(NUM_VOICES - 1)) ? '0 : steal_q + VW'(1);
  // Retrigger beats free-voice allocation, which beats stealing.
  assign on_voice   = match_any ? match_idx : (free_any ? free_idx : steal_q);
  assign accept     = bus.note_valid && note_ready;

  assign has_write  = (op_q == OP_ON) || ((op_q == OP_OFF) && match_any) ||
                      ((op_q == OP_ALL) && (|active_q));
  assign more_write = ((op_q == OP_ON) && !second_q) || ((op_q == OP_ALL) && (|pend_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.all_off || bus.note_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = has_write ? S_SETUP : S_IDLE;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = more_write ? S_SETUP : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    note_ready  = (state_q == S_IDLE) && !bus.all_off;
    data_oe     = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    bus_clock_d = (state_d == S_STROBE);
  end

  always_comb begin
    op_d     = op_q;
    voice_d  = voice_q;
    steal_d  = steal_q;
    second_d = second_q;
    pend_d   = pend_q;
    active_d = active_q;
    keys_d   = keys_q;
    addr_d   = addr_q;
    data_d   = data_q;
    key_d    = key_q;
    incr_d   = incr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.all_off) begin
          op_d = OP_ALL;
        end else if (accept) begin
          op_d   = bus.note_on ? OP_ON : OP_OFF;
          key_d  = bus.note_key;
          incr_d = bus.note_incr;
        end
      end
      S_LOOKUP: begin
        unique case (op_q)
          OP_ON: begin
            voice_d  = on_voice;
            addr_d   = reg_addr(on_voice, 2'd0);
            data_d   = incr_q;
            second_d = 1'b0;
            if (!match_any && !free_any) steal_d = steal_next;
          end
          OP_OFF: begin
            if (match_any) begin
              voice_d = match_idx;
              addr_d  = reg_addr(match_idx, 2'd1);
              data_d  = 8'h00;
            end
          end
          default: begin
            if (|active_q) begin
              voice_d = lowest(active_q);
              addr_d  = reg_addr(lowest(active_q), 2'd1);
              data_d  = 8'h00;
              pend_d  = drop_lowest(active_q);
            end
          end
        endcase
      end
      S_HOLD: begin
        if (more_write) begin
          if (op_q == OP_ON) begin
            second_d = 1'b1;
            addr_d   = reg_addr(voice_q, 2'd1);
            data_d   = 8'h01;
          end else begin
            voice_d = lowest(pend_q);
            addr_d  = reg_addr(lowest(pend_q), 2'd1);
            data_d  = 8'h00;
            pend_d  = drop_lowest(pend_q);
          end
        end else begin
          // Voice bookkeeping commits only once the whole write list is out.
          unique case (op_q)
            OP_ON: begin
              active_d[voice_q] = 1'b1;
              keys_d[voice_q]   = key_q;
            end
            OP_OFF:  active_d[voice_q] = 1'b0;
            default: active_d = '0;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_ON;
      voice_q     <= '0;
      steal_q     <= '0;
      second_q    <= 1'b0;
      pend_q      <= '0;
      active_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bus_clock_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) keys_q[v] <= '0;
    end else begin
      op_q        <= op_d;
      voice_q     <= voice_d;
      steal_q     <= steal_d;
      second_q    <= second_d;
      pend_q      <= pend_d;
      active_q    <= active_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bus_clock_q <= bus_clock_d;
      keys_q      <= keys_d;
    end
  end

  always_ff @(posedge clk) begin
    key_q  <= key_d;
    incr_q <= incr_d;
  end

  assign bus.note_ready     = note_ready;
  assign bus.bus_data_oe    = data_oe;
  assign bus.bus_address    = addr_q;
  assign bus.bus_data_o     = data_q;
  assign bus.bus_read_write = 1'b1;
  assign bus.bus_clock      = bus_clock_q;
  assign bus.voice_active   = active_q;
endmodule
